// File: rtl/debug_cmd_sequencer.sv
// Host-link command sequencer for the debug port: frames command bytes from the UART receiver,
// issues a held debug request, waits for ACK or timeout and returns the result bytes to the transmitter.
module debug_cmd_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter logic [7:0]  ACK_BYTE    = 8'hA5,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [2:0]  DEBUG_OP_O,
  output logic [2:0]  DEBUG_ARG_O,
  output logic        DEBUG_ADDR_INC_O,
  output logic        DEBUG_EN_BKP_O,
  output logic [15:0] DEBUG_DIN_O,
  output logic        DEBUG_LD_ADDR_O,
  output logic        DEBUG_REQ_O,
  input  logic        DEBUG_ACK_I,
  input  logic [15:0] DEBUG_DOUT_I
);

  // Debug op encoding; the unassigned eighth code is SET_ADDR.
  localparam logic [2:0] OP_RD_REG   = 3'd0;
  localparam logic [2:0] OP_RD_CC    = 3'd1;
  localparam logic [2:0] OP_RD_PC    = 3'd2;
  localparam logic [2:0] OP_RD_INSTR = 3'd3;
  localparam logic [2:0] OP_RD_MEM   = 3'd4;
  localparam logic [2:0] OP_WR_MEM   = 3'd5;
  localparam logic [2:0] OP_WR_BKP   = 3'd6;
  localparam logic [2:0] OP_SET_ADDR = 3'd7;

  localparam int            CNT_W      = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);
  localparam logic          TIMEOUT_EN = (ACK_TIMEOUT != 0);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PAY_HI   = 4'd1,
    ST_PAY_LO   = 4'd2,
    ST_ISSUE    = 4'd3,
    ST_WAIT_ACK = 4'd4,
    ST_LD_ADDR  = 4'd5,
    ST_TX_HI    = 4'd6,
    ST_TX_LO    = 4'd7,
    ST_TX_ONE   = 4'd8
  } state_t;

  function automatic logic has_payload(input logic [2:0] op);
    case (op)
      OP_WR_MEM, OP_WR_BKP, OP_SET_ADDR: has_payload = 1'b1;
      default:                           has_payload = 1'b0;
    endcase
  endfunction

  function automatic logic is_read(input logic [2:0] op);
    case (op)
      OP_RD_REG, OP_RD_CC, OP_RD_PC, OP_RD_INSTR, OP_RD_MEM: is_read = 1'b1;
      default:                                               is_read = 1'b0;
    endcase
  endfunction

  state_t           state_r, state_nxt_s;
  logic [2:0]       op_r, op_nxt_s;
  logic [2:0]       arg_r, arg_nxt_s;
  logic             inc_r, inc_nxt_s;
  logic             en_bkp_r, en_bkp_nxt_s;
  logic [15:0]      din_r, din_nxt_s;
  logic [15:0]      result_r, result_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             req_r, req_nxt_s;
  logic             ld_addr_r, ld_addr_nxt_s;
  logic             tx_valid_r, tx_valid_nxt_s;
  logic [7:0]       tx_data_r, tx_data_nxt_s;
  logic             rx_ready_r, rx_ready_nxt_s;
  logic             rx_fire_s;

  assign rx_fire_s = RX_VALID & rx_ready_r;

  // Next-state and next-output decode for the command sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    op_nxt_s       = op_r;
    arg_nxt_s      = arg_r;
    inc_nxt_s      = inc_r;
    en_bkp_nxt_s   = en_bkp_r;
    din_nxt_s      = din_r;
    result_nxt_s   = result_r;
    cnt_nxt_s      = cnt_r;
    req_nxt_s      = req_r;
    ld_addr_nxt_s  = 1'b0;
    tx_valid_nxt_s = tx_valid_r;
    tx_data_nxt_s  = tx_data_r;

    case (state_r)
      ST_IDLE: begin
        if (rx_fire_s) begin
          op_nxt_s     = RX_DATA[7:5];
          arg_nxt_s    = RX_DATA[4:2];
          inc_nxt_s    = RX_DATA[1];
          en_bkp_nxt_s = RX_DATA[0];
          if (has_payload(RX_DATA[7:5])) begin
            state_nxt_s = ST_PAY_HI;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAY_HI: begin
        if (rx_fire_s) begin
          din_nxt_s[15:8] = RX_DATA;
          state_nxt_s     = ST_PAY_LO;
        end else begin
          state_nxt_s = ST_PAY_HI;
        end
      end
      ST_PAY_LO: begin
        if (rx_fire_s) begin
          din_nxt_s[7:0] = RX_DATA;
          if (op_r == OP_SET_ADDR) begin
            state_nxt_s   = ST_LD_ADDR;
            ld_addr_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_PAY_LO;
        end
      end
      ST_LD_ADDR: begin
        state_nxt_s    = ST_TX_ONE;
        tx_valid_nxt_s = 1'b1;
        tx_data_nxt_s  = ACK_BYTE;
      end
      ST_ISSUE: begin
        req_nxt_s   = 1'b1;
        cnt_nxt_s   = '0;
        state_nxt_s = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // ACK takes priority over a timeout landing in the same cycle.
        if (DEBUG_ACK_I) begin
          req_nxt_s      = 1'b0;
          result_nxt_s   = DEBUG_DOUT_I;
          tx_valid_nxt_s = 1'b1;
          if (is_read(op_r)) begin
            state_nxt_s   = ST_TX_HI;
            tx_data_nxt_s = DEBUG_DOUT_I[15:8];
          end else begin
            state_nxt_s   = ST_TX_ONE;
            tx_data_nxt_s = ACK_BYTE;
          end
        end else if (TIMEOUT_EN && (cnt_r == CNT_MAX)) begin
          req_nxt_s      = 1'b0;
          state_nxt_s    = ST_TX_ONE;
          tx_valid_nxt_s = 1'b1;
          tx_data_nxt_s  = ERR_BYTE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_TX_HI: begin
        if (TX_READY) begin
          tx_data_nxt_s = result_r[7:0];
          state_nxt_s   = ST_TX_LO;
        end else begin
          state_nxt_s = ST_TX_HI;
        end
      end
      ST_TX_LO, ST_TX_ONE: begin
        if (TX_READY) begin
          tx_valid_nxt_s = 1'b0;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        req_nxt_s      = 1'b0;
        tx_valid_nxt_s = 1'b0;
      end
    endcase

    rx_ready_nxt_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_PAY_HI) ||
                     (state_nxt_s == ST_PAY_LO);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      op_r       <= 3'd0;
      arg_r      <= 3'd0;
      inc_r      <= 1'b0;
      en_bkp_r   <= 1'b0;
      din_r      <= 16'h0000;
      result_r   <= 16'h0000;
      cnt_r      <= '0;
      req_r      <= 1'b0;
      ld_addr_r  <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      rx_ready_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      op_r       <= op_nxt_s;
      arg_r      <= arg_nxt_s;
      inc_r      <= inc_nxt_s;
      en_bkp_r   <= en_bkp_nxt_s;
      din_r      <= din_nxt_s;
      result_r   <= result_nxt_s;
      cnt_r      <= cnt_nxt_s;
      req_r      <= req_nxt_s;
      ld_addr_r  <= ld_addr_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      rx_ready_r <= rx_ready_nxt_s;
    end
  end

  assign RX_READY         = rx_ready_r;
  assign TX_DATA          = tx_data_r;
  assign TX_VALID         = tx_valid_r;
  assign DEBUG_OP_O       = op_r;
  assign DEBUG_ARG_O      = arg_r;
  assign DEBUG_ADDR_INC_O = inc_r;
  assign DEBUG_EN_BKP_O   = en_bkp_r;
  assign DEBUG_DIN_O      = din_r;
  assign DEBUG_LD_ADDR_O  = ld_addr_r;
  assign DEBUG_REQ_O      = req_r;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Self-checking bench for debug_cmd_sequencer: response bytes go through a scoreboard queue,
// request/load-pulse timing is measured by a negedge monitor and checked per scenario.
module tb_debug_cmd_sequencer;
  localparam int unsigned TO = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;
  logic [2:0]  DEBUG_OP_O;
  logic [2:0]  DEBUG_ARG_O;
  logic        DEBUG_ADDR_INC_O;
  logic        DEBUG_EN_BKP_O;
  logic [15:0] DEBUG_DIN_O;
  logic        DEBUG_LD_ADDR_O;
  logic        DEBUG_REQ_O;
  logic        DEBUG_ACK_I = 1'b0;
  logic [15:0] DEBUG_DOUT_I = 16'h0000;

  debug_cmd_sequencer #(.ACK_TIMEOUT(TO), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
    .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .DEBUG_OP_O(DEBUG_OP_O), .DEBUG_ARG_O(DEBUG_ARG_O), .DEBUG_ADDR_INC_O(DEBUG_ADDR_INC_O),
    .DEBUG_EN_BKP_O(DEBUG_EN_BKP_O), .DEBUG_DIN_O(DEBUG_DIN_O), .DEBUG_LD_ADDR_O(DEBUG_LD_ADDR_O),
    .DEBUG_REQ_O(DEBUG_REQ_O), .DEBUG_ACK_I(DEBUG_ACK_I), .DEBUG_DOUT_I(DEBUG_DOUT_I)
  );

  initial forever #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] sb[$];

  int req_cycles, ld_cycles, req_rise_cyc, txv_rise_cyc, ack_cyc, accept_cyc;
  int pop_prev, pop_last;
  logic [15:0] ld_din, req_din;
  logic [2:0]  req_arg;
  logic req_q = 1'b0;
  logic txv_q = 1'b0;

  int stub_en = 1;
  int ack_delay = 1;
  int req_cnt = 0;
  logic [15:0] ack_data = 16'h0000;

  // Negedge monitor: timing measurements and scoreboard pop on each TX handshake.
  initial forever begin
    logic [7:0] exp_b;
    @(negedge CLK);
    cyc++;
    if (DEBUG_REQ_O) req_cycles++;
    if (DEBUG_REQ_O && !req_q) begin
      req_rise_cyc = cyc;
      req_din = DEBUG_DIN_O;
      req_arg = DEBUG_ARG_O;
    end
    if (DEBUG_LD_ADDR_O) begin
      ld_cycles++;
      ld_din = DEBUG_DIN_O;
    end
    if (DEBUG_ACK_I) ack_cyc = cyc;
    if (TX_VALID && !txv_q) txv_rise_cyc = cyc;
    if (TX_VALID && TX_READY) begin
      n_vec++;
      pop_prev = pop_last;
      pop_last = cyc;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got %h, expected no byte", TX_DATA);
      end else begin
        exp_b = sb.pop_front();
        if (TX_DATA !== exp_b) begin
          n_err++;
          $display("FAIL tx_byte: got %h, expected %h", TX_DATA, exp_b);
        end
      end
    end
    req_q = DEBUG_REQ_O;
    txv_q = TX_VALID;
  end

  // Debug-port stub: acks after ack_delay request cycles with ack_data.
  initial forever begin
    @(posedge CLK);
    #1;
    if (DEBUG_REQ_O && (stub_en != 0) && !DEBUG_ACK_I) begin
      if (req_cnt >= ack_delay) begin
        DEBUG_ACK_I = 1'b1;
        DEBUG_DOUT_I = ack_data;
        req_cnt = 0;
      end else begin
        req_cnt++;
      end
    end else begin
      DEBUG_ACK_I = 1'b0;
      DEBUG_DOUT_I = 16'h0000;
      req_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_meas();
    req_cycles = 0; ld_cycles = 0; req_rise_cyc = -1; txv_rise_cyc = -1;
    ack_cyc = -1; pop_prev = -1; pop_last = -1; ld_din = 16'h0; req_din = 16'h0; req_arg = 3'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    @(posedge CLK); #1;
    RX_DATA = b;
    RX_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (RX_READY) begin
        accept_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL rx_accept: byte %h not accepted, expected RX_READY within 100 cycles", b);
    end
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (sb.size() == 0 && !TX_VALID) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_done: %0d bytes outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_vec++;
    if ({RX_READY, TX_VALID, TX_DATA, DEBUG_REQ_O, DEBUG_LD_ADDR_O, DEBUG_OP_O, DEBUG_ARG_O,
         DEBUG_ADDR_INC_O, DEBUG_EN_BKP_O, DEBUG_DIN_O} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_outputs: some output nonzero (rdy=%b txv=%b txd=%h din=%h), expected all 0",
               RX_READY, TX_VALID, TX_DATA, DEBUG_DIN_O);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    n_vec++;
    if (RX_READY !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rx_ready: got %b, expected 1", RX_READY);
    end
  endtask

  task automatic test_set_addr();
    clear_meas();
    sb.push_back(8'hA5);
    send_byte(8'hE0);
    send_byte(8'h12);
    send_byte(8'h34);
    wait_idle("set_addr");
    n_vec++;
    if (ld_cycles != 1 || ld_din !== 16'h1234) begin
      n_err++;
      $display("FAIL set_addr_ld: pulses=%0d din=%h, expected 1 pulse with 1234", ld_cycles, ld_din);
    end
    n_vec++;
    if (req_cycles != 0) begin
      n_err++;
      $display("FAIL set_addr_req: req high %0d cycles, expected 0", req_cycles);
    end
  endtask

  task automatic test_rd_mem();
    clear_meas();
    stub_en = 1; ack_delay = 5; ack_data = 16'hBEEF;
    sb.push_back(8'hBE);
    sb.push_back(8'hEF);
    send_byte(8'h82);
    wait_idle("rd_mem");
    n_vec++;
    if (req_cycles != 6) begin
      n_err++;
      $display("FAIL rd_mem_req_len: req high %0d cycles, expected 6", req_cycles);
    end
    n_vec++;
    if (req_rise_cyc - accept_cyc != 2) begin
      n_err++;
      $display("FAIL rd_mem_req_latency: %0d cycles, expected 2", req_rise_cyc - accept_cyc);
    end
    n_vec++;
    if (txv_rise_cyc - ack_cyc != 1) begin
      n_err++;
      $display("FAIL rd_mem_ack_to_tx: %0d cycles, expected 1", txv_rise_cyc - ack_cyc);
    end
    n_vec++;
    if (pop_last - pop_prev != 1) begin
      n_err++;
      $display("FAIL rd_mem_back_to_back: byte gap %0d, expected 1", pop_last - pop_prev);
    end
    n_vec++;
    if (DEBUG_ADDR_INC_O !== 1'b1 || DEBUG_OP_O !== 3'd4) begin
      n_err++;
      $display("FAIL rd_mem_fields: inc=%b op=%0d, expected inc=1 op=4", DEBUG_ADDR_INC_O, DEBUG_OP_O);
    end
  endtask

  task automatic test_wr_mem_stall();
    logic seen;
    int bad;
    clear_meas();
    stub_en = 1; ack_delay = 1; ack_data = 16'h5555;
    TX_READY = 1'b0;
    sb.push_back(8'hA5);
    send_byte(8'hA0);
    send_byte(8'h00);
    send_byte(8'h7F);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (DEBUG_ACK_I) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL wr_mem_ack: ack seen=%b, expected 1", seen);
    end
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (TX_VALID !== 1'b1 || TX_DATA !== 8'hA5) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL wr_mem_hold: %0d cycles without held A5, expected 0 (last %b/%h)", bad, TX_VALID, TX_DATA);
    end
    @(posedge CLK); #1;
    TX_READY = 1'b1;
    wait_idle("wr_mem");
    n_vec++;
    if (req_din !== 16'h007F) begin
      n_err++;
      $display("FAIL wr_mem_din: got %h, expected 007F", req_din);
    end
  endtask

  task automatic test_timeout();
    clear_meas();
    stub_en = 0;
    sb.push_back(8'hEE);
    send_byte(8'h00);
    wait_idle("timeout");
    n_vec++;
    if (req_cycles != TO + 1) begin
      n_err++;
      $display("FAIL timeout_req_len: req high %0d cycles, expected %0d", req_cycles, TO + 1);
    end
    clear_meas();
    stub_en = 1; ack_delay = 2; ack_data = 16'h1357;
    sb.push_back(8'h13);
    sb.push_back(8'h57);
    send_byte(8'h20);
    wait_idle("after_timeout");
  endtask

  task automatic test_reset_mid();
    logic saw_tx;
    clear_meas();
    send_byte(8'hC1);
    n_vec++;
    if (DEBUG_EN_BKP_O !== 1'b1) begin
      n_err++;
      $display("FAIL wr_bkp_en: got %b, expected 1", DEBUG_EN_BKP_O);
    end
    send_byte(8'h55);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    saw_tx = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (TX_VALID || DEBUG_REQ_O) saw_tx = 1'b1;
    end
    n_vec++;
    if (saw_tx || RX_READY !== 1'b1 || DEBUG_DIN_O !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_mid: tx/req=%b rdy=%b din=%h, expected 0/1/0000", saw_tx, RX_READY, DEBUG_DIN_O);
    end
    clear_meas();
    stub_en = 1; ack_delay = 3; ack_data = 16'hCAFE;
    sb.push_back(8'hCA);
    sb.push_back(8'hFE);
    send_byte(8'h48);
    wait_idle("rd_pc");
    n_vec++;
    if (req_arg !== 3'b010 || DEBUG_OP_O !== 3'd2) begin
      n_err++;
      $display("FAIL rd_pc_arg: arg=%b op=%0d, expected arg=010 op=2", req_arg, DEBUG_OP_O);
    end
  endtask

  initial begin
    test_reset();
    test_set_addr();
    test_rd_mem();
    test_wr_mem_stall();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge CLK);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: %0d bytes left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
